rm_report_collector_lwsw: RTL and testbench
===========================================

Name: rm_report_collector_lwsw

Overview:
- Downstream consumer of the stage-0 lw/sw automata bank: 4 LTL checkers x 4 report outputs each, 16 report bits total.
- Tags every cycle that carries at least one report with the symbol index that produced it.
- Buffers tagged entries in a small FIFO and presents them to the monitor host over a valid/ready interface.
- Tracks loss with a sticky overflow flag and a saturating drop counter.

Parameters:
- NUM_REPORTS, 16, width of the report vector. Bit order: ltl0 out_4/6/9/11 in bits 0-3, then ltl1 in bits 4-7, ltl2 in bits 8-11, ltl3 in bits 12-15.
- IDX_W, 16, width of the symbol-index counter.
- FIFO_DEPTH, 8, number of buffered entries. Must be a power of 2 and at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- run  in  1  symbol-valid strobe, same qualifier as the automata stage
- report_in  in  NUM_REPORTS  automata report bits for the symbol accepted this cycle
- clr_overflow  in  1  clears overflow and drop_cnt
- rpt_valid  out  1  FIFO head entry is valid
- rpt_ready  in  1  host accepts the head entry
- rpt_vec  out  NUM_REPORTS  report vector of the head entry
- rpt_idx  out  IDX_W  symbol index of the head entry
- overflow  out  1  sticky; at least one entry has been dropped
- drop_cnt  out  DROP_W  count of dropped entries, saturating
- fill  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high) clears all state:
  - sym_idx=0, FIFO empty.
  - rpt_valid=0, rpt_vec=0, rpt_idx=0.
  - overflow=0, drop_cnt=0, fill=0.
- Reset asserted mid-operation discards all buffered entries in that cycle. Any capture or pop in that cycle is ignored.
- sym_idx counter:
  - Increments by 1 on every cycle with run=1.
  - Wraps from 2^IDX_W-1 to 0.
  - Holds when run=0.
- Capture condition: run=1 and report_in is non-zero.
  - The captured entry is {idx=sym_idx before increment, vec=report_in}.
  - report_in is ignored when run=0.
  - All-zero vectors are never stored.
- Push outcome for a captured entry:
  - FIFO not full: the entry is pushed.
  - FIFO full with a pop in the same cycle: the entry is pushed; occupancy stays at FIFO_DEPTH.
  - FIFO full with no pop: the entry is dropped, overflow is set, drop_cnt increments and saturates at 2^DROP_W-1.
- Handshake:
  - Pop occurs when rpt_valid=1 and rpt_ready=1.
  - rpt_valid=1 exactly when the FIFO is not empty.
  - rpt_vec and rpt_idx stay stable while rpt_valid=1 and rpt_ready=0.
  - rpt_ready is ignored while rpt_valid=0.
- Latency: an entry captured in cycle N first appears at the outputs in cycle N+1, given an empty FIFO. It is delivered no earlier than cycle N+1.
- Ordering: entries are delivered strictly in capture order (FIFO order).
- Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged and the head advances.
- Simultaneous push and pop on an empty FIFO is not possible, because rpt_valid=0.
- Overflow clearing:
  - clr_overflow=1 clears overflow and drop_cnt next cycle.
  - If a drop occurs in the same cycle as clr_overflow, the drop wins: overflow=1, drop_cnt=1.
- Pointers:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits.
  - full = (MSBs differ) and (lower bits equal).
  - empty = (pointers equal).
  - fill = wptr - rptr, modulo the pointer width.

Decomposition:
- Package rm_report_pkg holds:
  - the NUM_REPORTS, IDX_W and DROP_W defaults;
  - the ltl/output-to-bit index constants;
  - the packed entry struct {idx, vec}.
- One sub-module, rm_sync_fifo:
  - generic synchronous FIFO with synchronous reset;
  - push/pop/full/empty/fill ports;
  - head data shown combinationally from a register array.
- The top level contains only the index counter, capture logic, drop/overflow logic and the FIFO instance.

Test Plan:
- Reset, then hold run=1 with report_in=0 for 10 cycles -> rpt_valid stays 0, fill=0, and sym_idx reaches 10 (checked by a later capture).
- After 5 idle run cycles, drive run=1 with report_in=16'h0010 (ltl1 out_4) at cycle N, rpt_ready=1 -> rpt_valid=1 at N+1 with rpt_vec=16'h0010, rpt_idx=5. rpt_valid=0 at N+2.
- rpt_ready=0, 8 consecutive captures of vec=k+1 followed by a 9th capture -> fill=8, overflow=1, drop_cnt=1. Releasing rpt_ready then yields vecs 1..8 in order with consecutive idx values.
- FIFO full and rpt_ready=1 while capturing every cycle for 20 cycles -> no drops, fill stays 8, idx sequence contiguous.
- Assert reset with fill=5 while run=1 and report_in is non-zero -> next cycle fill=0, rpt_valid=0, overflow=0. The next capture reports idx=0.
- Set IDX_W=4 and run 17 cycles with a capture at cycles 15 and 16 -> idx=15 then idx=0 (wrap). Assert clr_overflow together with a drop -> overflow=1, drop_cnt=1.

Source files
------------

// File: rtl/rm_report_pkg.sv
// rm_report_pkg
//   Shared definitions for the lw/sw report collector.
//   - Default widths and depth for the collector and its FIFO.
//   - Bit positions of each LTL checker report output inside the 16-bit
//     report vector. Checker k owns bits 4k..4k+3, in the order
//     out_4, out_6, out_9, out_11.
//   - Packed buffered-entry layout {idx, vec} at the default widths.
package rm_report_pkg;

  localparam int DEF_NUM_REPORTS = 16;
  localparam int DEF_IDX_W       = 16;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_DROP_W      = 8;

  localparam int NUM_LTL      = 4;
  localparam int OUTS_PER_LTL = 4;

  // Report bit positions, one per checker output.
  localparam int LTL0_OUT4  = 0;
  localparam int LTL0_OUT6  = 1;
  localparam int LTL0_OUT9  = 2;
  localparam int LTL0_OUT11 = 3;
  localparam int LTL1_OUT4  = 4;
  localparam int LTL1_OUT6  = 5;
  localparam int LTL1_OUT9  = 6;
  localparam int LTL1_OUT11 = 7;
  localparam int LTL2_OUT4  = 8;
  localparam int LTL2_OUT6  = 9;
  localparam int LTL2_OUT9  = 10;
  localparam int LTL2_OUT11 = 11;
  localparam int LTL3_OUT4  = 12;
  localparam int LTL3_OUT6  = 13;
  localparam int LTL3_OUT9  = 14;
  localparam int LTL3_OUT11 = 15;

  // Buffered entry: symbol index in the upper field, report bits below.
  // The collector packs its FIFO word with this same {idx, vec} order.
  typedef struct packed {
    logic [DEF_IDX_W-1:0]       idx;
    logic [DEF_NUM_REPORTS-1:0] vec;
  } rpt_entry_t;

  // Report bit for checker 'ltl' and output slot 'out_slot' (0..3 for
  // out_4, out_6, out_9, out_11).
  function automatic int rpt_bit(input int ltl, input int out_slot);
    return ltl * OUTS_PER_LTL + out_slot;
  endfunction

endpackage

// File: rtl/rm_report_collector_lwsw_if.sv
// rm_report_collector_lwsw_if
//   Valid/ready report stream from the collector to the monitor host.
//   - rpt_valid : head entry present
//   - rpt_ready : host accepts the head entry
//   - rpt_vec   : report vector of the head entry
//   - rpt_idx   : symbol index of the head entry
//   master = collector side, slave = host side.
interface rm_report_collector_lwsw_if
  import rm_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int IDX_W       = DEF_IDX_W
);

  logic                   rpt_valid;
  logic                   rpt_ready;
  logic [NUM_REPORTS-1:0] rpt_vec;
  logic [IDX_W-1:0]       rpt_idx;

  modport master (
    output rpt_valid,
    output rpt_vec,
    output rpt_idx,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_vec,
    input  rpt_idx,
    output rpt_ready
  );

endinterface

// File: rtl/rm_report_collector_lwsw_fifo.sv
// rm_sync_fifo
//   Generic single-clock FIFO with synchronous active-high reset.
//   Ports:
//   - clk, reset          : clock, synchronous reset (empties the FIFO)
//   - push, push_data     : write request and data; ignored when full
//                           unless a pop happens in the same cycle
//   - pop                 : read request; ignored when empty
//   - head_data           : oldest entry, combinational from the array;
//                           forced to zero while empty
//   - full, empty, fill   : status; fill is the current occupancy
//   DEPTH must be a power of two and at least 2. Pointers carry one extra
//   wrap bit so full and empty are distinguishable without a counter.
module rm_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    fill
);

  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                 (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
  assign fill  = wptr_reg - rptr_reg;

  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a write when it is also being read.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + PW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + PW'(1);
    end
  end

  // Storage has no reset; stale contents are never visible because the
  // head output is masked while empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (do_push && (wptr_reg[AW-1:0] == AW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  assign head_data = empty ? '0 : mem_reg[rptr_reg[AW-1:0]];

endmodule

// File: rtl/rm_report_collector_lwsw.sv
// rm_report_collector_lwsw
//   Collects report bits from the stage-0 lw/sw automata bank, tags each
//   reporting symbol with its index and queues it for the monitor host.
//   Ports:
//   - clk, reset    : clock, synchronous active-high reset
//   - run           : symbol-valid strobe
//   - report_in     : report bits of the symbol accepted this cycle
//   - clr_overflow  : clears overflow and drop_cnt (a same-cycle drop wins)
//   - rpt_if        : valid/ready stream of {rpt_vec, rpt_idx} to the host
//   - overflow      : sticky, an entry has been lost
//   - drop_cnt      : saturating count of lost entries
//   - fill          : FIFO occupancy
module rm_report_collector_lwsw
  import rm_report_pkg::*;
#(
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int DROP_W      = DEF_DROP_W,
  localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [NUM_REPORTS-1:0]     report_in,
  input  logic                       clr_overflow,
  rm_report_collector_lwsw_if.master rpt_if,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [FILL_W-1:0]          fill
);

  localparam int ENTRY_W = IDX_W + NUM_REPORTS;

  logic [IDX_W-1:0]   sym_idx_reg;
  logic               overflow_reg;
  logic [DROP_W-1:0]  drop_cnt_reg;

  logic               capture;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Symbol index: counts accepted symbols, wraps naturally at 2^IDX_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_idx_reg <= '0;
    end else if (run) begin
      sym_idx_reg <= sym_idx_reg + IDX_W'(1);
    end
  end

  // Only symbols that actually reported something are worth buffering.
  assign capture    = run && (report_in != '0);
  assign push_entry = {sym_idx_reg, report_in};

  assign pop  = rpt_if.rpt_valid && rpt_if.rpt_ready;
  // Full FIFO with a same-cycle pop still has room; only a stalled full
  // FIFO loses the entry.
  assign drop = capture && fifo_full && !pop;

  // Loss tracking. A drop in the clearing cycle is counted as the first
  // loss after the clear rather than being swallowed by it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clr_overflow) begin
        drop_cnt_reg <= DROP_W'(1);
      end else if (drop_cnt_reg != {DROP_W{1'b1}}) begin
        drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
      end
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  rm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign rpt_if.rpt_valid = !fifo_empty;
  assign rpt_if.rpt_idx   = head_entry[ENTRY_W-1:NUM_REPORTS];
  assign rpt_if.rpt_vec   = head_entry[NUM_REPORTS-1:0];

  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_rm_report_collector_lwsw.sv
// Directed bench for rm_report_collector_lwsw. dut1 uses the default
// parameters; dut2 uses IDX_W=4, FIFO_DEPTH=2, DROP_W=2 to reach index
// wrap and drop-counter saturation quickly.
module tb_rm_report_collector_lwsw;
  import rm_report_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // dut1 (defaults)
  logic        reset1, run1, clr1;
  logic [15:0] rep1;
  logic        ovf1;
  logic [7:0]  drop1;
  logic [3:0]  fill1;
  rm_report_collector_lwsw_if #(.NUM_REPORTS(16), .IDX_W(16)) bus1 ();

  rm_report_collector_lwsw dut1 (
    .clk(clk), .reset(reset1), .run(run1), .report_in(rep1),
    .clr_overflow(clr1), .rpt_if(bus1), .overflow(ovf1),
    .drop_cnt(drop1), .fill(fill1)
  );

  // dut2 (small)
  logic        reset2, run2, clr2;
  logic [15:0] rep2;
  logic        ovf2;
  logic [1:0]  drop2;
  logic [1:0]  fill2;
  rm_report_collector_lwsw_if #(.NUM_REPORTS(16), .IDX_W(4)) bus2 ();

  rm_report_collector_lwsw #(
    .NUM_REPORTS(16), .IDX_W(4), .FIFO_DEPTH(2), .DROP_W(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .report_in(rep2),
    .clr_overflow(clr2), .rpt_if(bus2), .overflow(ovf2),
    .drop_cnt(drop2), .fill(fill2)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset2 = 1'b1;
    step(); step();
    reset1 = 1'b0; reset2 = 1'b0;
    n_vec++; if (bus1.rpt_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid got=%0h exp=0", bus1.rpt_valid); end
    n_vec++; if (bus1.rpt_vec !== 16'h0) begin n_miss++; $display("FAIL rst_vec got=%h exp=0000", bus1.rpt_vec); end
    n_vec++; if (bus1.rpt_idx !== 16'h0) begin n_miss++; $display("FAIL rst_idx got=%h exp=0000", bus1.rpt_idx); end
    n_vec++; if (ovf1 !== 1'b0) begin n_miss++; $display("FAIL rst_overflow got=%0h exp=0", ovf1); end
    n_vec++; if (drop1 !== 8'h0) begin n_miss++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop1); end
    n_vec++; if (fill1 !== 4'd0) begin n_miss++; $display("FAIL rst_fill got=%0d exp=0", fill1); end
    n_vec++; if (bus2.rpt_valid !== 1'b0 || fill2 !== 2'd0) begin n_miss++; $display("FAIL rst_dut2 got valid=%0h fill=%0d exp 0/0", bus2.rpt_valid, fill2); end
    $display("reset done");
  endtask

  // 10 idle symbols, then a capture must carry idx 10.
  task automatic test_idle_run();
    bus1.rpt_ready = 1'b1; run1 = 1'b1; rep1 = 16'h0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_vec++; if (bus1.rpt_valid !== 1'b0 || fill1 !== 4'd0) begin n_miss++; $display("FAIL idle_c%0d got valid=%0h fill=%0d exp 0/0", c, bus1.rpt_valid, fill1); end
    end
    rep1 = 16'h1 << LTL0_OUT4;
    step();
    rep1 = 16'h0; run1 = 1'b0;
    n_vec++; if (bus1.rpt_valid !== 1'b1 || bus1.rpt_idx !== 16'd10 || bus1.rpt_vec !== 16'h0001) begin n_miss++; $display("FAIL idle_capture got v=%0h idx=%0d vec=%h exp 1/10/0001", bus1.rpt_valid, bus1.rpt_idx, bus1.rpt_vec); end
    $display("idle capture idx=%0d vec=%h", bus1.rpt_idx, bus1.rpt_vec);
    step();
    n_vec++; if (bus1.rpt_valid !== 1'b0) begin n_miss++; $display("FAIL idle_drain got=%0h exp=0", bus1.rpt_valid); end
  endtask

  task automatic test_latency();
    reset1 = 1'b1; step(); reset1 = 1'b0;
    bus1.rpt_ready = 1'b1; run1 = 1'b1; rep1 = 16'h0;
    repeat (5) step();
    rep1 = 16'h1 << LTL1_OUT4;
    // cycle N: no combinational bypass to the outputs
    n_vec++; if (bus1.rpt_valid !== 1'b0) begin n_miss++; $display("FAIL lat_N got=%0h exp=0", bus1.rpt_valid); end
    step();
    rep1 = 16'h0; run1 = 1'b0;
    n_vec++; if (bus1.rpt_valid !== 1'b1 || bus1.rpt_vec !== 16'h0010 || bus1.rpt_idx !== 16'd5) begin n_miss++; $display("FAIL lat_N1 got v=%0h vec=%h idx=%0d exp 1/0010/5", bus1.rpt_valid, bus1.rpt_vec, bus1.rpt_idx); end
    $display("latency entry idx=%0d vec=%h", bus1.rpt_idx, bus1.rpt_vec);
    step();
    n_vec++; if (bus1.rpt_valid !== 1'b0) begin n_miss++; $display("FAIL lat_N2 got=%0h exp=0", bus1.rpt_valid); end
  endtask

  task automatic test_overflow();
    reset1 = 1'b1; step(); reset1 = 1'b0;
    bus1.rpt_ready = 1'b0; run1 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rep1 = 16'(k + 1);
      step();
    end
    run1 = 1'b0; rep1 = 16'h0;
    n_vec++; if (fill1 !== 4'd8) begin n_miss++; $display("FAIL ovf_fill got=%0d exp=8", fill1); end
    n_vec++; if (ovf1 !== 1'b1) begin n_miss++; $display("FAIL ovf_flag got=%0h exp=1", ovf1); end
    n_vec++; if (drop1 !== 8'd1) begin n_miss++; $display("FAIL ovf_drop got=%0d exp=1", drop1); end
    step();
    n_vec++; if (bus1.rpt_vec !== 16'h0001 || bus1.rpt_idx !== 16'd0) begin n_miss++; $display("FAIL ovf_stall got vec=%h idx=%0d exp 0001/0", bus1.rpt_vec, bus1.rpt_idx); end
    bus1.rpt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (bus1.rpt_valid !== 1'b1 || bus1.rpt_vec !== 16'(k + 1) || bus1.rpt_idx !== 16'(k)) begin n_miss++; $display("FAIL ovf_pop%0d got v=%0h vec=%h idx=%0d exp 1/%h/%0d", k, bus1.rpt_valid, bus1.rpt_vec, bus1.rpt_idx, 16'(k + 1), k); end
      $display("pop idx=%0d vec=%h", bus1.rpt_idx, bus1.rpt_vec);
      step();
    end
    n_vec++; if (bus1.rpt_valid !== 1'b0 || fill1 !== 4'd0 || ovf1 !== 1'b1) begin n_miss++; $display("FAIL ovf_drained got v=%0h fill=%0d ovf=%0h exp 0/0/1", bus1.rpt_valid, fill1, ovf1); end
    clr1 = 1'b1; step(); clr1 = 1'b0;
    n_vec++; if (ovf1 !== 1'b0 || drop1 !== 8'd0) begin n_miss++; $display("FAIL ovf_clear got ovf=%0h drop=%0d exp 0/0", ovf1, drop1); end
  endtask

  // Full FIFO, host draining and source capturing every cycle.
  task automatic test_back_to_back();
    rpt_entry_t q[$];
    rpt_entry_t exp_e;
    reset1 = 1'b1; step(); reset1 = 1'b0;
    bus1.rpt_ready = 1'b0; run1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rep1 = 16'(k + 1);
      q.push_back('{idx: 16'(k), vec: 16'(k + 1)});
      step();
    end
    bus1.rpt_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rep1 = 16'h0100 + 16'(c);
      exp_e = q.pop_front();
      n_vec++; if (bus1.rpt_idx !== exp_e.idx || bus1.rpt_vec !== exp_e.vec || fill1 !== 4'd8) begin n_miss++; $display("FAIL b2b_c%0d got idx=%0d vec=%h fill=%0d exp %0d/%h/8", c, bus1.rpt_idx, bus1.rpt_vec, fill1, exp_e.idx, exp_e.vec); end
      $display("b2b pop idx=%0d vec=%h", bus1.rpt_idx, bus1.rpt_vec);
      q.push_back('{idx: 16'(8 + c), vec: rep1});
      step();
    end
    run1 = 1'b0; rep1 = 16'h0; bus1.rpt_ready = 1'b0;
    n_vec++; if (ovf1 !== 1'b0 || drop1 !== 8'd0 || fill1 !== 4'd8) begin n_miss++; $display("FAIL b2b_nodrop got ovf=%0h drop=%0d fill=%0d exp 0/0/8", ovf1, drop1, fill1); end
    n_vec++; if (bus1.rpt_idx !== 16'd20 || bus1.rpt_vec !== 16'h010C) begin n_miss++; $display("FAIL b2b_head got idx=%0d vec=%h exp 20/010c", bus1.rpt_idx, bus1.rpt_vec); end
  endtask

  task automatic test_reset_midop();
    reset1 = 1'b1; step(); reset1 = 1'b0;
    bus1.rpt_ready = 1'b0; run1 = 1'b1; rep1 = 16'hA5A5;
    repeat (9) step();           // 8 stored, 1 dropped
    run1 = 1'b0; bus1.rpt_ready = 1'b1;
    repeat (3) step();           // 5 left
    bus1.rpt_ready = 1'b0;
    n_vec++; if (fill1 !== 4'd5 || ovf1 !== 1'b1) begin n_miss++; $display("FAIL mid_pre got fill=%0d ovf=%0h exp 5/1", fill1, ovf1); end
    reset1 = 1'b1; run1 = 1'b1; rep1 = 16'h00FF; bus1.rpt_ready = 1'b1;
    step();
    reset1 = 1'b0; rep1 = 16'h1 << LTL3_OUT11;
    n_vec++; if (fill1 !== 4'd0 || bus1.rpt_valid !== 1'b0 || ovf1 !== 1'b0) begin n_miss++; $display("FAIL mid_reset got fill=%0d v=%0h ovf=%0h exp 0/0/0", fill1, bus1.rpt_valid, ovf1); end
    step();
    run1 = 1'b0; rep1 = 16'h0;
    n_vec++; if (bus1.rpt_valid !== 1'b1 || bus1.rpt_idx !== 16'd0 || bus1.rpt_vec !== 16'h8000) begin n_miss++; $display("FAIL mid_after got v=%0h idx=%0d vec=%h exp 1/0/8000", bus1.rpt_valid, bus1.rpt_idx, bus1.rpt_vec); end
    step();
  endtask

  task automatic test_wrap();
    bus2.rpt_ready = 1'b1; run2 = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c == 16) begin
        n_vec++; if (bus2.rpt_valid !== 1'b1 || bus2.rpt_idx !== 4'd15 || bus2.rpt_vec !== 16'h0040) begin n_miss++; $display("FAIL wrap_15 got v=%0h idx=%0d vec=%h exp 1/15/0040", bus2.rpt_valid, bus2.rpt_idx, bus2.rpt_vec); end
        $display("wrap pop idx=%0d vec=%h", bus2.rpt_idx, bus2.rpt_vec);
      end
      rep2 = (c == 15) ? 16'h0040 : (c == 16) ? 16'h1000 : 16'h0;
      step();
    end
    run2 = 1'b0; rep2 = 16'h0;
    n_vec++; if (bus2.rpt_valid !== 1'b1 || bus2.rpt_idx !== 4'd0 || bus2.rpt_vec !== 16'h1000) begin n_miss++; $display("FAIL wrap_0 got v=%0h idx=%0d vec=%h exp 1/0/1000", bus2.rpt_valid, bus2.rpt_idx, bus2.rpt_vec); end
    $display("wrap pop idx=%0d vec=%h", bus2.rpt_idx, bus2.rpt_vec);
    step();
    n_vec++; if (bus2.rpt_valid !== 1'b0) begin n_miss++; $display("FAIL wrap_empty got=%0h exp=0", bus2.rpt_valid); end
  endtask

  task automatic test_clr_with_drop();
    bus2.rpt_ready = 1'b0; run2 = 1'b1; rep2 = 16'h0002;
    step(); step();
    n_vec++; if (fill2 !== 2'd2 || ovf2 !== 1'b0) begin n_miss++; $display("FAIL clr_full got fill=%0d ovf=%0h exp 2/0", fill2, ovf2); end
    step();
    n_vec++; if (ovf2 !== 1'b1 || drop2 !== 2'd1) begin n_miss++; $display("FAIL clr_drop1 got ovf=%0h drop=%0d exp 1/1", ovf2, drop2); end
    step(); step(); step();      // 4 drops total, counter saturates at 3
    n_vec++; if (drop2 !== 2'd3) begin n_miss++; $display("FAIL clr_sat got=%0d exp=3", drop2); end
    clr2 = 1'b1; step();
    n_vec++; if (ovf2 !== 1'b1 || drop2 !== 2'd1) begin n_miss++; $display("FAIL clr_vs_drop got ovf=%0h drop=%0d exp 1/1", ovf2, drop2); end
    run2 = 1'b0; rep2 = 16'h0;
    step(); clr2 = 1'b0;
    n_vec++; if (ovf2 !== 1'b0 || drop2 !== 2'd0 || fill2 !== 2'd2) begin n_miss++; $display("FAIL clr_only got ovf=%0h drop=%0d fill=%0d exp 0/0/2", ovf2, drop2, fill2); end
  endtask

  initial begin
    reset1 = 1'b1; run1 = 1'b0; clr1 = 1'b0; rep1 = 16'h0; bus1.rpt_ready = 1'b0;
    reset2 = 1'b1; run2 = 1'b0; clr2 = 1'b0; rep2 = 16'h0; bus2.rpt_ready = 1'b0;
    test_reset();
    test_idle_run();
    test_latency();
    test_overflow();
    test_back_to_back();
    test_reset_midop();
    test_wrap();
    test_clr_with_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
